// File: rtl/dadd_cfg_seq.sv
// dadd_cfg_seq: APB master sequencer that writes the dadd control register
// ({addend, en}), reads it back, retries on a readback mismatch and reports
// ok / mismatch / timeout on a one-cycle completion pulse.
module dadd_cfg_seq #(
    parameter int APB_AWIDTH = 32,
    parameter int APB_DWIDTH = 32,
    parameter int REG_ADDR   = 0,
    parameter int MAX_RETRY  = 2,
    parameter int TIMEOUT    = 16
) (
    input  logic                  pclk,
    input  logic                  rst,
    input  logic                  cfg_req,
    input  logic                  cfg_en,
    input  logic [4:0]            cfg_addend,
    output logic                  cfg_ready,
    output logic                  cfg_done,
    output logic [1:0]            cfg_err,
    output logic                  busy,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [APB_AWIDTH-1:0] paddr,
    output logic [APB_DWIDTH-1:0] pwdata,
    input  logic                  pready,
    input  logic [APB_DWIDTH-1:0] prdata
);

    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_OK       = 2'd0;
    localparam logic [1:0] ST_MISMATCH = 2'd1;
    localparam logic [1:0] ST_TIMEOUT  = 2'd2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_SETUP  = 3'd1,
        WR_ACCESS = 3'd2,
        RD_SETUP  = 3'd3,
        RD_ACCESS = 3'd4,
        CHECK     = 3'd5,
        DONE      = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic            en_q, en_d;
    logic [4:0]      addend_q, addend_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [5:0]      rdbk_q, rdbk_d;
    logic [1:0]      err_q, err_d;

    // Only the low six readback bits carry the register; the rest are ignored.
    logic unused_prdata;
    assign unused_prdata = ^prdata;

    // Register all sequencer state; reset abandons any transfer in flight.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            en_q     <= 1'b0;
            addend_q <= '0;
            retry_q  <= '0;
            tmo_q    <= '0;
            rdbk_q   <= '0;
            err_q    <= ST_OK;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            addend_q <= addend_d;
            retry_q  <= retry_d;
            tmo_q    <= tmo_d;
            rdbk_q   <= rdbk_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic: request capture, APB phase sequencing, timeout and retry.
    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        addend_d = addend_q;
        retry_d  = retry_q;
        tmo_d    = tmo_q;
        rdbk_d   = rdbk_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (cfg_req) begin
                    en_d     = cfg_en;
                    addend_d = cfg_addend;
                    retry_d  = '0;
                    tmo_d    = '0;
                    state_d  = WR_SETUP;
                end
            end
            WR_SETUP: begin
                tmo_d   = '0;
                state_d = WR_ACCESS;
            end
            WR_ACCESS: begin
                if (pready) begin
                    state_d = RD_SETUP;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    err_d   = ST_TIMEOUT;
                    state_d = DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            RD_SETUP: begin
                tmo_d   = '0;
                state_d = RD_ACCESS;
            end
            RD_ACCESS: begin
                if (pready) begin
                    rdbk_d  = prdata[5:0];
                    state_d = CHECK;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    err_d   = ST_TIMEOUT;
                    state_d = DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            CHECK: begin
                if (rdbk_q == {addend_q, en_q}) begin
                    err_d   = ST_OK;
                    state_d = DONE;
                end else if (retry_q < RW'(MAX_RETRY)) begin
                    retry_d = retry_q + 1'b1;
                    state_d = WR_SETUP;
                end else begin
                    err_d   = ST_MISMATCH;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from registered state and captured values only (no pready/prdata path).
    always_comb begin
        psel      = 1'b0;
        penable   = 1'b0;
        pwrite    = 1'b0;
        paddr     = '0;
        pwdata    = '0;
        cfg_ready = (state_q == IDLE);
        busy      = (state_q != IDLE);
        cfg_done  = (state_q == DONE);
        cfg_err   = err_q;
        case (state_q)
            WR_SETUP, WR_ACCESS: begin
                psel        = 1'b1;
                penable     = (state_q == WR_ACCESS);
                pwrite      = 1'b1;
                paddr       = APB_AWIDTH'(REG_ADDR);
                pwdata[5:0] = {addend_q, en_q};
            end
            RD_SETUP, RD_ACCESS: begin
                psel    = 1'b1;
                penable = (state_q == RD_ACCESS);
                paddr   = APB_AWIDTH'(REG_ADDR);
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_dadd_cfg_seq.sv
// Testbench for dadd_cfg_seq: behavioural APB register slave with
// programmable wait states / fault injection, table of sequences and a
// completion scoreboard, plus hand-written reset and back-to-back sequences.
module tb_dadd_cfg_seq;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 16;
    localparam int MR  = 2;

    logic          pclk = 1'b0;
    logic          rst;
    logic          cfg_req;
    logic          cfg_en;
    logic [4:0]    cfg_addend;
    logic          cfg_ready;
    logic          cfg_done;
    logic [1:0]    cfg_err;
    logic          busy;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          pready;
    logic [DW-1:0] prdata;

    dadd_cfg_seq #(
        .APB_AWIDTH(AW),
        .APB_DWIDTH(DW),
        .REG_ADDR  (0),
        .MAX_RETRY (MR),
        .TIMEOUT   (TMO)
    ) dut (
        .pclk      (pclk),
        .rst       (rst),
        .cfg_req   (cfg_req),
        .cfg_en    (cfg_en),
        .cfg_addend(cfg_addend),
        .cfg_ready (cfg_ready),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .busy      (busy),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pready    (pready),
        .prdata    (prdata)
    );

    always #5 pclk = ~pclk;

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // ---------------- APB slave model ----------------
    int          wr_wait = 0;
    int          rd_wait = 0;
    bit          faulty  = 1'b0;
    int          wcnt    = 0;
    int          wr_setups = 0;
    int          rd_setups = 0;
    int          stab_err  = 0;
    logic [5:0]  mem = '0;
    logic [31:0] last_wdata = '0;
    logic [AW-1:0] s_addr = '0;
    logic [DW-1:0] s_data = '0;
    logic          s_wr   = 1'b0;

    initial begin
        pready = 1'b0;
        prdata = '0;
    end

    always @(negedge pclk) begin
        if (psel && !penable) begin
            s_addr = paddr;
            s_data = pwdata;
            s_wr   = pwrite;
            if (pwrite) begin
                wr_setups++;
                last_wdata = pwdata;
            end else begin
                rd_setups++;
                if (pwdata != '0) stab_err++;
            end
            if (paddr != '0) stab_err++;
            pready = 1'b0;
            prdata = '0;
            wcnt   = 0;
        end else if (psel && penable) begin
            if (paddr != s_addr || pwdata != s_data || pwrite != s_wr) stab_err++;
            if (wcnt < (pwrite ? wr_wait : rd_wait)) begin
                pready = 1'b0;
                wcnt++;
            end else begin
                pready = 1'b1;
                if (pwrite) mem = pwdata[5:0];
            end
            prdata = faulty ? '0 : {26'b0, mem};
        end else begin
            pready = 1'b0;
            prdata = '0;
            wcnt   = 0;
        end
    end

    // ---------------- vectors and scoreboard ----------------
    typedef struct {
        logic       en;
        logic [4:0] add;
        int         ww;
        int         rw;
        bit         flt;
        logic [1:0] err;
        int         lat;
        int         nwr;
        int         nrd;
    } vec_t;

    typedef struct {
        logic [1:0]  err;
        int          lat;
        int          nwr;
        int          nrd;
        logic [31:0] wd;
    } exp_t;

    exp_t sb[$];
    vec_t vt[11];

    task automatic wait_done(output bit seen, output int n);
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 200) begin
            @(negedge pclk);
            n++;
            if (cfg_done) seen = 1'b1;
        end
    endtask

    task automatic run_seq(input vec_t v, input string nm);
        exp_t e;
        bit   seen;
        int   n;
        wr_wait = v.ww;
        rd_wait = v.rw;
        faulty  = v.flt;
        @(negedge pclk);
        wr_setups = 0;
        rd_setups = 0;
        stab_err  = 0;
        chk({nm, "_ready_before"}, cfg_ready, 1);
        cfg_en     = v.en;
        cfg_addend = v.add;
        cfg_req    = 1'b1;
        sb.push_back('{v.err, v.lat, v.nwr, v.nrd, {26'b0, v.add, v.en}});
        @(posedge pclk);
        #1 cfg_req = 1'b0;
        wait_done(seen, n);
        e = sb.pop_front();
        chk({nm, "_done_seen"}, seen, 1);
        if (seen) begin
            chk({nm, "_latency"}, n, e.lat);
            chk({nm, "_err"}, cfg_err, e.err);
            chk({nm, "_wr_setups"}, wr_setups, e.nwr);
            chk({nm, "_rd_setups"}, rd_setups, e.nrd);
            chk({nm, "_pwdata"}, last_wdata, e.wd);
            chk({nm, "_apb_stable"}, stab_err, 0);
            @(negedge pclk);
            chk({nm, "_done_one_cycle"}, cfg_done, 0);
            chk({nm, "_err_hold"}, cfg_err, e.err);
            chk({nm, "_ready_after"}, cfg_ready, 1);
        end
    endtask

    initial begin
        bit   seen;
        int   n;
        exp_t e;

        // en, add, ww, rw, flt, err, lat, nwr, nrd
        vt[0]  = '{1'b1, 5'h0B, 0,    0,    1'b0, 2'd0, 6,  1, 1};  // nominal 0x17
        vt[1]  = '{1'b1, 5'h0B, 3,    3,    1'b0, 2'd0, 12, 1, 1};  // 3 wait states each access
        vt[2]  = '{1'b0, 5'h1F, 0,    0,    1'b0, 2'd0, 6,  1, 1};
        vt[3]  = '{1'b1, 5'h00, 2,    2,    1'b0, 2'd0, 10, 1, 1};
        vt[4]  = '{1'b1, 5'h15, 15,   0,    1'b0, 2'd0, 21, 1, 1};  // pready on last allowed cycle
        vt[5]  = '{1'b1, 5'h0B, 0,    0,    1'b1, 2'd1, 16, 3, 3};  // faulty slave, two retries
        vt[6]  = '{1'b1, 5'h0B, 3,    3,    1'b1, 2'd1, 34, 3, 3};
        vt[7]  = '{1'b0, 5'h00, 0,    0,    1'b1, 2'd0, 6,  1, 1};  // zero readback matches zero request
        vt[8]  = '{1'b1, 5'h0B, 1000, 0,    1'b0, 2'd2, 18, 1, 0};  // stuck slave on write
        vt[9]  = '{1'b1, 5'h0A, 16,   0,    1'b0, 2'd2, 18, 1, 0};  // one cycle too many
        vt[10] = '{1'b1, 5'h03, 0,    1000, 1'b0, 2'd2, 20, 1, 1};  // stuck slave on read

        rst        = 1'b1;
        cfg_req    = 1'b0;
        cfg_en     = 1'b0;
        cfg_addend = '0;
        repeat (3) @(negedge pclk);
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_cfg_done", cfg_done, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge pclk);
        chk("rst_cfg_ready", cfg_ready, 1);

        for (int i = 0; i < 11; i++) begin
            run_seq(vt[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of a read access (slave holds pready low).
        chk("pre_rst_err_nonzero", cfg_err, 2);
        wr_wait = 0;
        rd_wait = 1000;
        faulty  = 1'b0;
        @(negedge pclk);
        cfg_en     = 1'b1;
        cfg_addend = 5'h0B;
        cfg_req    = 1'b1;
        @(posedge pclk);
        #1 cfg_req = 1'b0;
        n = 0;
        while (!(psel && penable && !pwrite) && n < 50) begin
            @(negedge pclk);
            n++;
        end
        chk("mid_reach_rd_access", psel && penable && !pwrite, 1);
        @(negedge pclk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_psel", psel, 0);
        chk("mid_rst_penable", penable, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", cfg_ready, 1);
        chk("mid_rst_err", cfg_err, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge pclk);
            chk("mid_rst_no_done", cfg_done, 0);
        end
        rst     = 1'b0;
        rd_wait = 0;
        @(negedge pclk);
        chk("post_rst_no_done", cfg_done, 0);
        chk("post_rst_idle", busy, 0);
        run_seq(vt[0], "post_rst");

        // cfg_req held high: back-to-back sequences with one IDLE cycle between.
        wr_wait = 0;
        rd_wait = 0;
        faulty  = 1'b0;
        @(negedge pclk);
        wr_setups  = 0;
        cfg_en     = 1'b1;
        cfg_addend = 5'h0B;
        cfg_req    = 1'b1;
        sb.push_back('{2'd0, 6, 1, 1, 32'h17});
        wait_done(seen, n);
        e = sb.pop_front();
        chk("held1_done_seen", seen, 1);
        chk("held1_err", cfg_err, e.err);
        chk("held1_pwdata", last_wdata, e.wd);
        chk("held1_wr_setups", wr_setups, e.nwr);
        cfg_en     = 1'b0;
        cfg_addend = 5'h04;
        sb.push_back('{2'd0, 6, 1, 1, 32'h08});
        @(negedge pclk);
        chk("held_gap_ready", cfg_ready, 1);
        chk("held_gap_busy", busy, 0);
        wr_setups = 0;
        wait_done(seen, n);
        cfg_req = 1'b0;
        e = sb.pop_front();
        chk("held2_done_seen", seen, 1);
        chk("held2_latency", n, e.lat);
        chk("held2_err", cfg_err, e.err);
        chk("held2_pwdata", last_wdata, e.wd);
        chk("held2_wr_setups", wr_setups, e.nwr);
        repeat (2) @(negedge pclk);
        chk("held_end_idle", cfg_ready, 1);

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/dadd_cfg_seq.md
DADD_CFG_SEQ -- requirements
Module: dadd_cfg_seq

Interface
REQ-001 SHALL have parameter APB_AWIDTH, default 32, APB address width.
REQ-002 SHALL have parameter APB_DWIDTH, default 32, APB data width.
REQ-003 SHALL have parameter REG_ADDR, default 0, APB address of the dadd control register.
REQ-004 SHALL have parameter MAX_RETRY, default 2, write/readback retries after the first attempt fails to compare.
REQ-005 SHALL have parameter TIMEOUT, default 16, maximum access-phase cycles waiting for pready.
REQ-006 One clock, pclk; reset rst is asynchronous and active-high.
REQ-007 pclk  input  1  clock, rising edge.
REQ-008 rst  input  1  asynchronous active-high reset.
REQ-009 cfg_req  input  1  configuration request.
REQ-010 cfg_en  input  1  requested dadd enable bit.
REQ-011 cfg_addend  input  5  requested addend value.
REQ-012 cfg_ready  output  1  sequencer can accept a request.
REQ-013 cfg_done  output  1  one-cycle completion pulse.
REQ-014 cfg_err  output  2  completion status: 0 ok, 1 readback mismatch, 2 timeout.
REQ-015 busy  output  1  a sequence is in progress.
REQ-016 psel, penable, pwrite  output  1 each  APB master control.
REQ-017 paddr  output  APB_AWIDTH  APB address.
REQ-018 pwdata  output  APB_DWIDTH  APB write data.
REQ-019 pready  input  1  APB ready.
REQ-020 prdata  input  APB_DWIDTH  APB read data.

Function
REQ-021 SHALL use the FSM states IDLE, WR_SETUP, WR_ACCESS, RD_SETUP, RD_ACCESS, CHECK, DONE, all registered.
REQ-022 cfg_ready SHALL be 1 only in IDLE, and busy SHALL be 1 in every other state.
REQ-023 On cfg_req && cfg_ready, the FSM SHALL capture cfg_en and cfg_addend, clear the retry and timeout counters, and go to WR_SETUP; cfg_req outside IDLE is ignored.
REQ-024 In WR_SETUP: psel=1, penable=0, pwrite=1, paddr=REG_ADDR, pwdata={zeros, addend[4:0], en}.
REQ-025 WR_SETUP SHALL always advance to WR_ACCESS after exactly one cycle.
REQ-026 In WR_ACCESS: psel=1, penable=1, and address, data and pwrite held from WR_SETUP.
REQ-027 WR_ACCESS SHALL advance to RD_SETUP in the cycle pready=1 is sampled.
REQ-028 In RD_SETUP: psel=1, penable=0, pwrite=0, paddr=REG_ADDR, pwdata=0, followed by RD_ACCESS (penable=1).
REQ-029 In RD_ACCESS, when pready=1 the FSM SHALL register prdata[5:0] and go to CHECK.
REQ-030 The timeout counter SHALL clear on entry to each ACCESS state and count access cycles with pready=0.
REQ-031 When the timeout counter reaches TIMEOUT-1 with pready still 0, the FSM SHALL drop psel/penable next cycle, set status 2, and go to DONE; no retry follows a timeout.
REQ-032 CHECK SHALL compare the registered readback with {addend, en}.
REQ-033 On match in CHECK, the FSM SHALL set status 0 and go to DONE.
REQ-034 On mismatch in CHECK with retry count < MAX_RETRY, the FSM SHALL increment the retry count and go to WR_SETUP.
REQ-035 On mismatch in CHECK otherwise, the FSM SHALL set status 1 and go to DONE.
REQ-036 In DONE, cfg_done=1 for exactly one cycle and cfg_err=status, then the FSM returns to IDLE.
REQ-037 cfg_err SHALL hold its value until the next DONE.
REQ-038 Outside SETUP/ACCESS states: psel=penable=pwrite=0, paddr=0, pwdata=0.
REQ-039 No back-to-back requests: the earliest next acceptance is the cycle after DONE.
REQ-040 Best-case latency, accept to cfg_done with pready=1 and a match, SHALL be 6 cycles: WR_SETUP, WR_ACCESS, RD_SETUP, RD_ACCESS, CHECK, DONE.
REQ-041 All APB outputs SHALL be registered or decoded from registered state only, with no combinational path from pready/prdata to the outputs.

Reset
REQ-042 rst=1 SHALL force, asynchronously: state IDLE, psel=penable=pwrite=0, paddr=0, pwdata=0, cfg_done=0, cfg_err=0, busy=0, cfg_ready=1 after release, and all counters and captured values 0.
REQ-043 Reset mid-sequence SHALL abandon the transfer without any cfg_done pulse; the first request after release starts a fresh sequence.

Verification
REQ-044 Nominal: cfg_en=1, cfg_addend=5'h0B, slave pready=1 and stores value -> APB write pwdata=0x17, read returns 0x17, cfg_done 6 cycles after accept, cfg_err=0.
REQ-045 Wait states: pready low 3 cycles in each access -> phases extended, signals stable, cfg_done at cycle 12, cfg_err=0.
REQ-046 Stuck slave: pready=0 forever, TIMEOUT=16 -> psel drops after 16 access cycles, cfg_err=2, exactly one read/write setup seen.
REQ-047 Faulty slave returns 0x00 for request 0x17 -> 3 write+read pairs (MAX_RETRY=2), then cfg_err=1.
REQ-048 Reset asserted during RD_ACCESS -> psel/penable 0 immediately, no cfg_done; new request after release completes with cfg_err=0.
REQ-049 cfg_req held high continuously -> consecutive sequences separated by at least one IDLE cycle, each capturing the current cfg inputs.
